// File: rtl/wiener_axis_tx_if.sv
// wiener_axis_tx_if
//
// Video AXI4-Stream bundle carrying filtered pixels out of the Wiener
// pipeline.
//
// Signals
//   tdata   pixel word, {8'h0, R, G, B}
//   tvalid  beat valid
//   tready  downstream accepts the beat
//   tlast   last pixel of a line
//   tuser   first pixel of a frame
//
// Modports
//   master  drives tdata/tvalid/tlast/tuser, samples tready
//   slave   the mirror image, for the consumer side

interface wiener_axis_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/wiener_axis_tx.sv
// wiener_axis_tx
//
// Output-side AXI4-Stream transmitter of the Wiener denoising pipeline.
// Filtered pixels arrive on a valid/ready push port, are buffered in a
// small FIFO together with their start-of-frame flag, and leave as a video
// AXI4-Stream (tuser = start of frame, tlast = end of line).
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   frame_width        pixels per line (>= 1), sampled on every use
//   frame_height       lines per frame (>= 1)
//   in_data/in_valid   filtered pixel and its qualifier
//   in_sof             pixel is the first of a frame
//   in_ready           FIFO can take a pixel this cycle
//   m_axis             AXI4-Stream master (wiener_axis_tx_if.master)
//   frame_done         one-cycle pulse after the final beat of a frame
//   sof_err            sticky framing error
//
// Optional feature
//   WIENER_AXIS_TX_SOF_CHECK_EN  when defined, sof_err flags truncated
//   frames (sof seen mid-frame) and missing sofs; otherwise sof_err is 0.

module wiener_axis_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  wiener_axis_tx_if.master      m_axis,
  output logic                  frame_done,
  output logic                  sof_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Entry layout: {sof, pixel}. Storage is data-only and never reset.
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [15:0]         col;
  logic [15:0]         row;

  logic [DATA_WIDTH:0] head;
  logic                head_sof;
  logic [15:0]         eff_col;
  logic [15:0]         eff_row;
  logic                tvalid;
  logic                tlast;
  logic                frame_end;
  logic                wr_en;
  logic                rd_en;

  // No pass-through when full: a read in the same cycle does not free the slot early.
  assign in_ready = (count != (AW+1)'(FIFO_DEPTH));
  assign tvalid   = (count != '0);
  assign wr_en    = in_valid & in_ready;
  assign rd_en    = tvalid & m_axis.tready;

  assign head     = mem[rd_ptr];
  assign head_sof = head[DATA_WIDTH];

  // A stored sof forces the position back to the frame origin, so the
  // counters resynchronise to whatever framing the upstream stage sends.
  assign eff_col   = head_sof ? 16'd0 : col;
  assign eff_row   = head_sof ? 16'd0 : row;
  assign tlast     = tvalid & (eff_col == frame_width - 16'd1);
  assign frame_end = tlast & (eff_row == frame_height - 16'd1);

  // Everything below depends only on the head entry and the counters, which
  // move only on a handshake, so the beat stays stable while stalled.
  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis.tuser  = tvalid & head_sof;
  assign m_axis.tlast  = tlast;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_sof, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= rd_en & frame_end;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_en) begin
        if (tlast) begin
          col <= '0;
          row <= frame_end ? 16'd0 : eff_row + 16'd1;
        end else begin
          col <= eff_col + 16'd1;
          row <= eff_row;
        end
      end
    end
  end

`ifdef WIENER_AXIS_TX_SOF_CHECK_EN
  // started keeps the very first beat after reset from being called a
  // missing sof when no frame has been seen yet.
  logic started;

  always_ff @(posedge clk) begin
    if (rst) begin
      started <= 1'b0;
      sof_err <= 1'b0;
    end else if (rd_en) begin
      started <= 1'b1;
      if (head_sof && (col != 16'd0 || row != 16'd0)) begin
        sof_err <= 1'b1;
      end
      if (!head_sof && col == 16'd0 && row == 16'd0 && started) begin
        sof_err <= 1'b1;
      end
    end
  end
`else
  assign sof_err = 1'b0;
`endif

endmodule

// File: doc/wiener_axis_tx.md
# wiener_axis_tx

Output-side AXI4-Stream transmitter for the Wiener denoising pipeline. Accepts filtered pixels from the Wiener calculation stage through a valid/ready push interface and buffers them in a small FIFO. Re-emits them as a video AXI4-Stream master with `tuser` marking start-of-frame and `tlast` marking end-of-line. It is the transmit counterpart of the AXI-stream receiver that writes incoming frames into frame memory.

## Interface

Parameters
- `DATA_WIDTH`, 32: pixel word width (`{8'h0, R, G, B}` packing, passed through untouched).
- `FIFO_DEPTH`, 16: buffer entries; power of two, at least 2.

Ports
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `frame_width`  in  16: pixels per line; sampled on every use; must be at least 1.
- `frame_height`  in  16: lines per frame; must be at least 1.
- `in_data`  in  DATA_WIDTH: filtered pixel from the Wiener stage.
- `in_valid`  in  1: `in_data` valid.
- `in_sof`  in  1: qualifies `in_data` as the first pixel of a frame.
- `in_ready`  out  1: FIFO can accept a pixel this cycle.
- `m_axis_tdata`  out  DATA_WIDTH: output pixel.
- `m_axis_tvalid`  out  1: output beat valid.
- `m_axis_tready`  in  1: downstream accepts the beat.
- `m_axis_tlast`  out  1: last pixel of a line.
- `m_axis_tuser`  out  1: first pixel of a frame.
- `frame_done`  out  1: one-cycle pulse after the final beat of a frame is accepted.
- `sof_err`  out  1: sticky protocol error (see Configuration).

## Operation

- FIFO entry = `{in_sof, in_data}`. A write happens when `in_valid && in_ready`. A read happens when `m_axis_tvalid && m_axis_tready`.
- `in_ready = (count != FIFO_DEPTH)`. There is no pass-through when full: a simultaneous read does not raise `in_ready` in the same cycle.
- `m_axis_tvalid = (count != 0)`. `m_axis_tdata` and `m_axis_tuser` come from the head entry. `m_axis_tdata` is driven 0 while `m_axis_tvalid` is low.
- Output position counters `col` (16 bit) and `row` (16 bit) count accepted beats.
  - Effective position: if the head entry's sof bit is set, use (0,0); otherwise use (`col`,`row`).
  - `m_axis_tlast = m_axis_tvalid && (eff_col == frame_width-1)`.
  - On a read, `col` becomes `eff_col+1`, or 0 if `tlast` is asserted. `row` increments on each `tlast`.
  - When `tlast` coincides with `eff_row == frame_height-1`, both counters return to 0 and `frame_done` pulses in the next cycle.
- `m_axis_tuser` is the stored sof bit only. It is never synthesised from the counters.
- AXI rule: once `m_axis_tvalid` is high, `tdata`, `tlast` and `tuser` remain stable until the handshake completes.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. `count` is `$clog2(FIFO_DEPTH)+1` bits wide. A simultaneous read and write leaves `count` unchanged.

## Timing

- Reset values: `in_ready=1`, `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `m_axis_tuser=0`, `frame_done=0`, `sof_err=0`. Pointers, `count`, `col` and `row` are all 0.
- Latency: a write on edge k makes the pixel visible on `m_axis_*` after edge k. With an empty FIFO, `tvalid` rises in the cycle after the write edge.
- Throughput: one beat per cycle sustained when `tready` is held high.
- `frame_done`: registered, high for exactly one cycle following the final-beat edge.
- Reset mid-frame flushes the FIFO and counters. Any beat presented but not yet accepted is lost. `m_axis_tvalid` is low in the first cycle after reset.

## Configuration

- `WIENER_AXIS_TX_SOF_CHECK_EN` defined:
  - `sof_err` sets on a read of a sof-flagged entry while (`col`,`row`) is not (0,0), i.e. a frame was truncated.
  - `sof_err` also sets on a read of a non-sof entry at (0,0) after the first frame has started, i.e. a missing SOF.
  - `sof_err` clears only on `rst`. The beat itself is still transmitted and the counters resynchronise as described in Operation.
- Not defined: `sof_err` is tied to 0 and no checking logic is built. The datapath is identical.

## Test plan

- Frame 16x16, 256 pixels pushed with `tready=1` and `in_sof` on pixel 0: 256 beats out in order; `tuser` only on beat 0; `tlast` on beats 15, 31, …, 255; `frame_done` one cycle after beat 255; first `tvalid` one cycle after the first write.
- Backpressure, `FIFO_DEPTH=16`: hold `tready=0` while pushing 20 pixels. `in_ready` falls after write 16 and `count` stays at 16. Releasing `tready` drains pixels 0..15 intact, then pixels 16..19 follow.
- Full FIFO with simultaneous read and write in the same cycle: the write is refused (`in_ready=0`), `count` goes 16 to 15, and `in_ready=1` in the next cycle.
- Reset mid-frame after 37 beats accepted: all outputs return to reset values. The next frame with `in_sof` starts at beat 0 with `tlast` at beat 15.
- With the macro defined: `frame_width=8`, `frame_height=2`, send 5 pixels then a new `in_sof`. `sof_err` goes to 1 and stays 1; the new frame's `tlast` lands on its beat 7.
- Width 1, height 1: every beat carries `tuser=1` and `tlast=1`, and `frame_done` pulses after every beat.
